// File: rtl/seq_mult_unit.sv
// seq_mult_unit: sequential shift-add multiplier with its own control FSM.
// Consumes one multiplier bit per clock and supports unsigned or
// two's-complement operands. Operands are reduced to magnitudes on start,
// and the sign is applied once at the end. Product is held in a register
// until the next Done pulse.
//
// Optional feature macro: SEQ_MULT_EARLY_EXIT_EN
//   When it is defined, CALC stops as soon as the remaining multiplier bits
//   are all zero. Results are unchanged; only latency shrinks.
//   When it is not defined, CALC always runs for exactly WIDTH cycles, and
//   no zero-detect logic exists.

module seq_mult_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 St,
  input  logic                 Sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Idle,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } stateType;

  stateType         state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             lastStep;

  // Unsigned magnitude of an operand. The most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits, so nothing
  // saturates.
  function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] x,
                                             input logic             sgn);
    if (sgn && x[WIDTH-1])
      return (~x) + WIDTH'(1);
    else
      return x;
  endfunction

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Leave CALC after the last counted bit, or once no set multiplier bits remain after this shift.
  assign lastStep = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  // Leave CALC after exactly WIDTH bit steps.
  assign lastStep = (cnt == CW'(WIDTH - 1));
`endif

  // Status outputs are decoded directly from the state register.
  assign Idle = (state == IDLE);
  assign Busy = (state == CALC) || (state == SIGN);
  assign Done = (state == DONE);

  // Control FSM and datapath. On start, the operands are captured as
  // magnitudes. One shift-add step runs per CALC cycle. SIGN applies the
  // result sign into the held Product register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            mcand  <= {{WIDTH{1'b0}}, magOf(A, Sgn)};
            mplier <= magOf(B, Sgn);
            neg    <= Sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (lastStep)
            state <= SIGN;
        end
        SIGN: begin
          Product <= neg ? ((~acc) + PW'(1)) : acc;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: self-checking bench for seq_mult_unit at WIDTH=8.
// A table of directed operand/product vectors is followed by hand-written
// multi-cycle sequences: busy length, ignored restart, mid-operation reset
// and back-to-back operation.

module tb_seq_mult_unit;

  localparam int WIDTH = 8;

  logic              Clk;
  logic              reset_n;
  logic              St;
  logic              Sgn;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              Idle;
  logic              Busy;
  logic              Done;
  logic [2*WIDTH-1:0] Product;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          earlyEdge;
  } vecType;

  vecType vecs[12];

  seq_mult_unit #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .St      (St),
    .Sgn     (Sgn),
    .A       (A),
    .B       (B),
    .Idle    (Idle),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Absolute edge counter used to measure the Done period.
  always @(posedge Clk) edgeCount <= edgeCount + 1;

  // Done edge for a vector, depending on the build.
  function automatic int expEdge(input int earlyEdge);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    return earlyEdge;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pulse St for one cycle with the given operands. Edge 0 is the sampling edge.
  // The operands are then scrambled to show that they are no longer used.
  task automatic applyStimulus(input logic sgn, input logic [7:0] a,
                               input logic [7:0] b);
    @(negedge Clk);
    St = 1'b1; Sgn = sgn; A = a; B = b;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0; Sgn = ~sgn; A = 8'hAA; B = 8'h55;
  endtask

  // Return the edge number (relative to edge 0) after which Done is high, or -1.
  task automatic waitDone(output int edgeNum);
    edgeNum = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        edgeNum = k;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int busyCnt;
    int doneCnt;
    int holdBad;
    int doneAt[3];
    int nDone;
    int period;

    vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'h008F, 5};
    vecs[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 4};
    vecs[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 9};
    vecs[3]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 9};
    vecs[4]  = '{1'b1, 8'hFD,  8'hFB,  16'h000F, 4};
    vecs[5]  = '{1'b1, 8'h05,  8'hFF,  16'hFFFB, 2};
    vecs[6]  = '{1'b0, 8'd100, 8'd1,   16'd100,  2};
    vecs[7]  = '{1'b0, 8'd3,   8'd0,   16'd0,    2};
    vecs[8]  = '{1'b0, 8'd1,   8'h80,  16'd128,  9};
    vecs[9]  = '{1'b1, 8'h80,  8'h01,  16'hFF80, 2};
    vecs[10] = '{1'b1, 8'h7F,  8'h7F,  16'h3F01, 8};
    vecs[11] = '{1'b1, 8'd7,   8'd9,   16'd63,   5};

    reset_n = 1'b0; St = 1'b0; Sgn = 1'b0; A = '0; B = '0;
    #2;
    checkOutput("resetIdle",    32'(Idle),    32'd1);
    checkOutput("resetBusy",    32'(Busy),    32'd0);
    checkOutput("resetDone",    32'(Done),    32'd0);
    checkOutput("resetProduct", 32'(Product), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
      waitDone(e);
      checkOutput($sformatf("doneEdge[%0d]", i), 32'(e), 32'(expEdge(vecs[i].earlyEdge)));
      checkOutput($sformatf("product[%0d]", i), 32'(Product), 32'(vecs[i].prod));
      @(posedge Clk); #1;
      checkOutput($sformatf("doneLow[%0d]", i), 32'(Done), 32'd0);
      checkOutput($sformatf("idleAfter[%0d]", i), 32'(Idle), 32'd1);
    end

    // Busy length: 13 x 11.
    applyStimulus(1'b0, 8'd13, 8'd11);
    busyCnt = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (Done) break;
      if (Busy) busyCnt++;
    end
    checkOutput("busyCycles", 32'(busyCnt), 32'(expEdge(5) - 0));
    @(posedge Clk); #1;

    // A restart request while busy is ignored: one Done, 7 x 9 = 63, then held.
    applyStimulus(1'b0, 8'd7, 8'd9);
    repeat (3) @(negedge Clk);
    St = 1'b1; A = 8'd2; B = 8'd2;
    @(negedge Clk);
    St = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (Done) doneCnt++;
    end
    checkOutput("ignoredStDones", 32'(doneCnt), 32'd1);
    checkOutput("ignoredStProduct", 32'(Product), 32'd63);
    holdBad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (Product !== 16'd63 || !Idle) holdBad++;
    end
    checkOutput("productHold", 32'(holdBad), 32'd0);

    // Reset in the middle of an operation aborts it and clears Product.
    applyStimulus(1'b0, 8'd200, 8'd3);
    repeat (5) @(posedge Clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midResetIdle",    32'(Idle),    32'd1);
    checkOutput("midResetBusy",    32'(Busy),    32'd0);
    checkOutput("midResetDone",    32'(Done),    32'd0);
    checkOutput("midResetProduct", 32'(Product), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'd5, 8'd5);
    waitDone(e);
    checkOutput("afterResetEdge",    32'(e),       32'(expEdge(4)));
    checkOutput("afterResetProduct", 32'(Product), 32'd25);
    @(posedge Clk); #1;

    // Back-to-back: St held high, so Done repeats with a fixed period.
    @(negedge Clk);
    St = 1'b1; Sgn = 1'b0; A = 8'd6; B = 8'd7;
    nDone = 0;
    for (int k = 0; k < 60 && nDone < 3; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        doneAt[nDone] = edgeCount;
        checkOutput($sformatf("b2bProduct[%0d]", nDone), 32'(Product), 32'd42);
        nDone++;
      end
    end
    St = 1'b0;
    checkOutput("b2bDoneCount", 32'(nDone), 32'd3);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    period = 6;
`else
    period = WIDTH + 3;
`endif
    if (nDone == 3) begin
      checkOutput("b2bPeriod0", 32'(doneAt[1] - doneAt[0]), 32'(period));
      checkOutput("b2bPeriod1", 32'(doneAt[2] - doneAt[1]), 32'(period));
    end
    repeat (15) @(posedge Clk);
    #1;
    checkOutput("finalIdle", 32'(Idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Parametrised sequential shift-add multiplier with its own control FSM and datapath.
- Successor to the fixed-width multiplier control unit. Adds a WIDTH parameter, a signed/unsigned mode, a busy/done handshake and a held product register.
- Processes one multiplier bit per clock.
- Sits beside the ALU as the multi-cycle MULT resource. The CPU control stalls on Busy and latches Product on Done.

Parameters:
- WIDTH, 8, operand width in bits (≥2). Product is 2*WIDTH bits.
- CW, $clog2(WIDTH), width of the internal bit counter.

Ports:
- Clk  in  1  system clock; rising edge active.
- reset_n  in  1  asynchronous, active-low reset.
- St  in  1  start request; sampled only in IDLE.
- Sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with St.
- A  in  WIDTH  multiplicand; sampled with St.
- B  in  WIDTH  multiplier; sampled with St.
- Idle  out  1  high while the FSM is in IDLE.
- Busy  out  1  high in CALC and SIGN.
- Done  out  1  single-cycle pulse; Product is valid.
- Product  out  2*WIDTH  result register; holds its value until the next Done.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, Product=0, Done=0, Busy=0, Idle=1.
  - All internal registers are cleared.
  - A reset mid-operation aborts the operation. No Done is issued and Product is 0.
- Outputs:
  - Idle and Busy are decoded from state.
  - Done is decoded from state==DONE.
  - Product is a register.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE:
  - If St=1 at the edge, capture the operands and go to CALC. Otherwise stay in IDLE.
  - Capture values:
    - mcand = |A|, zero-extended to 2*WIDTH bits.
    - mplier = |B| (WIDTH bits).
    - neg = Sgn & (A[msb]^B[msb]).
    - acc = 0, cnt = 0.
  - Magnitude rule: |x| = x when Sgn=0 or x[msb]=0; otherwise |x| = (~x+1) taken as an unsigned WIDTH-bit value.
  - -2^(WIDTH-1) therefore yields magnitude 2^(WIDTH-1). It must not saturate or overflow.
- CALC (one bit per cycle):
  - If mplier[0]=1, acc += mcand (modulo 2^(2*WIDTH)).
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - Go to SIGN after the cycle in which cnt==WIDTH-1 (exactly WIDTH CALC cycles). Otherwise stay in CALC.
- SIGN:
  - Product <= neg ? (~acc+1) : acc.
  - Go to DONE.
- DONE:
  - Done=1 for one cycle.
  - Return to IDLE unconditionally.
- Latency: take the rising edge that samples St as edge 0. Done is high after edge WIDTH+1 and low after edge WIDTH+2. For WIDTH=8 that is edge 9.
- St asserted in CALC, SIGN or DONE is ignored; there is no queueing. St held high through DONE starts a new operation on the edge where the FSM is back in IDLE.
- Operand changes while Busy have no effect.
- Product changes only on the SIGN→DONE edge and on reset.
- Any unencoded state returns to IDLE on the next edge.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined: CALC also exits to SIGN after any cycle in which the post-shift mplier==0, i.e. (mplier>>1)==0.
  - CALC therefore lasts max(1, index_of_highest_set_bit(|B|)+1) cycles.
  - Done arrives after edge (CALC cycles + 1).
  - Results are identical to those without the macro.
- Undefined: fixed WIDTH CALC cycles, with no zero-detect logic synthesised.

Test Plan:
- WIDTH=8, Sgn=0, A=13, B=11, St pulsed for 1 cycle → Busy for 9 cycles, Done pulse at edge 9, Product=16'h008F (143), Idle=1 afterwards.
- Sgn=1, A=8'hFD (-3), B=8'h05 → Product=16'hFFF1 (-15). Then A=8'h80, B=8'h80 → Product=16'h4000 (16384). Then Sgn=0, A=B=8'hFF → Product=16'hFE01.
- Start 7×9. Pulse St again with A=2, B=2 at edge 4 → ignored; the single Done gives Product=63. Product holds 63 for 20 idle cycles.
- Start 200×3 and drive reset_n=0 at edge 5 → immediately Idle=1, Busy=0, Product=0, no Done. After release, 5×5 gives 25 with normal latency.
- Back-to-back: St held high continuously with A=6, B=7 → Done every WIDTH+3 cycles, Product=42 each time.
- With SEQ_MULT_EARLY_EXIT_EN: A=100, B=1 → Done at edge 2, Product=100. A=3, B=0 → Done at edge 2, Product=0. A=1, B=8'h80 → Done at edge 9, Product=128. Without the macro, all three give Done at edge 9.
